// File: rtl/gpio_in_conditioner.sv
// Input conditioner ahead of the GPIO peripheral: per-pin synchroniser, optional debounce,
// and a registered parity bit on the GPIOIN bus.
module gpio_in_conditioner #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [WIDTH-1:0] PIN_IN,
   input  logic             DEBOUNCE_EN,
   input  logic             PARITYSEL,
   input  logic             INJECT_ERR,
   output logic [WIDTH:0]   GPIOIN,
   output logic             CHANGE,
   output logic             STABLE
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_par;
   logic             r_change;
   logic             r_stable;

   logic [WIDTH-1:0] w_sync_out;
   logic [WIDTH-1:0] w_sync_next;
   logic [WIDTH-1:0] w_cand_next;
   logic [WIDTH-1:0] w_data_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_par_next;
   logic             w_stable_next;

   assign w_sync_out  = r_sync[SYNC_STAGES-1];
   assign w_sync_next = r_sync[SYNC_STAGES-2];

   always_comb begin
      w_cand_next = r_cand;
      w_cnt_next  = r_cnt;
      w_data_next = r_data;
      if (!DEBOUNCE_EN) begin
         // Bypass keeps the debouncer settled so re-enabling it cannot commit spuriously.
         w_cand_next = w_sync_out;
         w_cnt_next  = CntMax;
         w_data_next = w_sync_out;
      end else begin
         if (w_sync_out != r_cand) begin
            w_cand_next = w_sync_out;
            w_cnt_next  = '0;
         end else if (r_cnt < CntMax) begin
            w_cnt_next = r_cnt + 1'b1;
         end
         if ((r_cnt == CntMax) && (w_sync_out == r_cand) && (r_cand != r_data)) begin
            w_data_next = r_cand;
         end
      end
   end

   always_comb begin
      w_par_next    = (PARITYSEL ? ^w_data_next : ~^w_data_next) ^ INJECT_ERR;
      // Registered from next-state values so STABLE matches the settled condition this cycle.
      w_stable_next = !DEBOUNCE_EN ||
                      ((w_cnt_next == CntMax) && (w_sync_next == w_cand_next) &&
                       (w_cand_next == w_data_next));
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_cand   <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_par    <= 1'b0;
         r_change <= 1'b0;
         r_stable <= 1'b0;
      end else begin
         r_sync[0] <= PIN_IN;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_cand   <= w_cand_next;
         r_cnt    <= w_cnt_next;
         r_data   <= w_data_next;
         r_par    <= w_par_next;
         r_change <= (w_data_next != r_data);
         r_stable <= w_stable_next;
      end
   end

   assign GPIOIN = {r_par, r_data};
   assign CHANGE = r_change;
   assign STABLE = r_stable;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed vector table, a reset-mid-debounce sequence, and
// random stimulus checked against a run-length reference model.
module tb_gpio_in_conditioner;

   localparam int SYNC = 2;
   localparam int DC   = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [15:0] PIN_IN;
   logic        DEBOUNCE_EN;
   logic        PARITYSEL;
   logic        INJECT_ERR;
   logic [16:0] GPIOIN;
   logic        CHANGE;
   logic        STABLE;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_in_conditioner dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .PIN_IN      (PIN_IN),
      .DEBOUNCE_EN (DEBOUNCE_EN),
      .PARITYSEL   (PARITYSEL),
      .INJECT_ERR  (INJECT_ERR),
      .GPIOIN      (GPIOIN),
      .CHANGE      (CHANGE),
      .STABLE      (STABLE)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        rst_n;
      logic [15:0] pin;
      logic        den;
      logic        psel;
      logic        inj;
      logic [16:0] gpio;
      logic        chg;
      logic        stb;
   } vec_t;

   vec_t vecs[$];

   // Reference model: sync_out is the pin history delayed SYNC edges; the debouncer is a
   // run length of identical sync_out samples, committing after DC+1 equal samples.
   logic [15:0] m_pipe[$];
   logic [15:0] m_data;
   logic [15:0] m_last;
   int          m_run;
   logic        m_par;
   logic        m_chg;
   logic        m_stb;

   function automatic void model_edge();
      logic [15:0] s;
      logic [15:0] nd;
      if (!HRESETn) begin
         m_pipe.delete();
         for (int i = 0; i < SYNC; i++) m_pipe.push_back(16'h0);
         m_data = '0;
         m_last = '0;
         m_run  = 1;
         m_par  = 1'b0;
         m_chg  = 1'b0;
         m_stb  = 1'b0;
      end else begin
         s  = m_pipe[0];
         nd = m_data;
         if (!DEBOUNCE_EN) begin
            nd     = s;
            m_last = s;
            m_run  = DC;
         end else begin
            if (s == m_last) m_run = (m_run < DC + 1) ? m_run + 1 : DC + 1;
            else begin
               m_last = s;
               m_run  = 1;
            end
            if (m_run >= DC + 1 && s != m_data) nd = s;
         end
         m_par  = (PARITYSEL ? ^nd : ~^nd) ^ INJECT_ERR;
         m_chg  = (nd != m_data);
         m_data = nd;
         void'(m_pipe.pop_front());
         m_pipe.push_back(PIN_IN);
         m_stb = !DEBOUNCE_EN || (m_run >= DC && m_pipe[0] == m_last && m_last == m_data);
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic void add(input logic rst_n, input logic [15:0] pin, input logic den,
                               input logic psel, input logic inj, input logic [16:0] gpio,
                               input logic chg, input logic stb);
      vec_t v;
      v = '{rst_n, pin, den, psel, inj, gpio, chg, stb};
      vecs.push_back(v);
   endfunction

   initial begin
      HRESETn     = 1'b0;
      PIN_IN      = 16'hFFFF;
      DEBOUNCE_EN = 1'b0;
      PARITYSEL   = 1'b0;
      INJECT_ERR  = 1'b0;

      // Reset, then bypass release with odd parity.
      repeat (3) add(0, 16'hFFFF, 0, 0, 0, 17'h00000, 0, 0);
      add(1, 16'hFFFF, 0, 0, 0, 17'h10000, 0, 1);
      add(1, 16'hFFFF, 0, 0, 0, 17'h10000, 0, 1);
      add(1, 16'hFFFF, 0, 0, 0, 17'h1FFFF, 1, 1);
      add(1, 16'hFFFF, 0, 0, 0, 17'h1FFFF, 0, 1);
      // Bypass, even parity: back to 0, then 0x00A5.
      add(1, 16'h0000, 0, 1, 0, 17'h0FFFF, 0, 1);
      add(1, 16'h0000, 0, 1, 0, 17'h0FFFF, 0, 1);
      add(1, 16'h0000, 0, 1, 0, 17'h00000, 1, 1);
      add(1, 16'h0000, 0, 1, 0, 17'h00000, 0, 1);
      add(1, 16'h00A5, 0, 1, 0, 17'h00000, 0, 1);
      add(1, 16'h00A5, 0, 1, 0, 17'h00000, 0, 1);
      add(1, 16'h00A5, 0, 1, 0, 17'h000A5, 1, 1);
      add(1, 16'h00A5, 0, 1, 0, 17'h000A5, 0, 1);
      add(1, 16'h00A5, 0, 1, 0, 17'h000A5, 0, 1);
      // Switch to debounce settled, then debounce a change to 0.
      add(1, 16'h0000, 1, 1, 0, 17'h000A5, 0, 1);
      repeat (5) add(1, 16'h0000, 1, 1, 0, 17'h000A5, 0, 0);
      add(1, 16'h0000, 1, 1, 0, 17'h00000, 1, 1);
      add(1, 16'h0000, 1, 1, 0, 17'h00000, 0, 1);
      // Debounced 0x1234: commit on the 7th edge after the change.
      add(1, 16'h1234, 1, 1, 0, 17'h00000, 0, 1);
      repeat (5) add(1, 16'h1234, 1, 1, 0, 17'h00000, 0, 0);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 1, 1);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 1);
      // Three-cycle glitch is rejected; STABLE drops and recovers.
      add(1, 16'h1235, 1, 1, 0, 17'h11234, 0, 1);
      add(1, 16'h1235, 1, 1, 0, 17'h11234, 0, 0);
      add(1, 16'h1235, 1, 1, 0, 17'h11234, 0, 0);
      repeat (5) add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 0);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 1);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 1);
      // One-cycle error injection and a parity-mode flip.
      add(1, 16'h1234, 1, 1, 1, 17'h01234, 0, 1);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 1);
      add(1, 16'h1234, 1, 0, 0, 17'h01234, 0, 1);
      add(1, 16'h1234, 1, 1, 0, 17'h11234, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         HRESETn     = vecs[i].rst_n;
         PIN_IN      = vecs[i].pin;
         DEBOUNCE_EN = vecs[i].den;
         PARITYSEL   = vecs[i].psel;
         INJECT_ERR  = vecs[i].inj;
         tick();
         check($sformatf("vec%0d gpioin", i), GPIOIN, vecs[i].gpio);
         check($sformatf("vec%0d change", i), 17'(CHANGE), 17'(vecs[i].chg));
         check($sformatf("vec%0d stable", i), 17'(STABLE), 17'(vecs[i].stb));
      end

      // Reset sampled low on edges 5 and 6 mid-debounce; commit only at edge 13.
      PIN_IN = 16'h00FF;
      for (int e = 1; e <= 14; e++) begin
         HRESETn = !(e == 5 || e == 6);
         tick();
         check($sformatf("rstmid e%0d gpioin", e), GPIOIN,
               (e <= 4) ? 17'h11234 : ((e < 13) ? 17'h00000 : 17'h000FF));
         check($sformatf("rstmid e%0d change", e), 17'(CHANGE), 17'(e == 13));
      end

      // Random phase against the reference model.
      HRESETn = 1'b0;
      tick();
      tick();
      for (int n = 0; n < 3000; n++) begin
         HRESETn = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 1) PIN_IN = 16'($urandom);
            else PIN_IN = PIN_IN ^ (16'(1) << $urandom_range(0, 15));
         end
         if ($urandom_range(0, 49) == 0) DEBOUNCE_EN = ~DEBOUNCE_EN;
         if ($urandom_range(0, 29) == 0) PARITYSEL = ~PARITYSEL;
         INJECT_ERR = ($urandom_range(0, 19) == 0);
         tick();
         check("rand gpioin", GPIOIN, {m_par, m_data});
         check("rand change", 17'(CHANGE), 17'(m_chg));
         check("rand stable", 17'(STABLE), 17'(m_stb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
